uart_rx_param: RTL and testbench

//  Parametrised UART receiver; next generation of the fixed 8N1 receiver that feeds uart_decoder.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_param.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and bit-period helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                                input int unsigned baud);
      return freq_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX line; flops reset to the idle (high) level.
module uart_rx_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with start-glitch rejection, framing errors and saturating error count.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned FREQUENCY_IN_HZ = 50_000_000,
   parameter int unsigned BAUD            = 9600,
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned PARITY_ODD      = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_rx,
   output logic                 io_data_valid,
   output logic [DATA_BITS-1:0] io_data_packet,
   output logic                 io_frame_error,
   output logic                 io_parity_error,
   output logic [7:0]           io_error_count,
   output logic                 io_busy
);

   localparam int unsigned CPB = clks_per_bit(FREQUENCY_IN_HZ, BAUD);
   localparam int unsigned CW  = $clog2(CPB);
   localparam int unsigned IW  = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_M1  = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CPB - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
   localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] sr_q, sr_d;
   logic                 par_bad_q, par_bad_d;
   logic                 valid_q, valid_d;
   logic [DATA_BITS-1:0] packet_q, packet_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic [7:0]           errcnt_q, errcnt_d;
   logic                 rx_s;

   uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .async_i(io_rx),
      .sync_o (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sr_d      = sr_q;
      par_bad_d = par_bad_q;
      packet_d  = packet_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      perr_d    = 1'b0;
      errcnt_d  = errcnt_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d     = '0;
               idx_d     = '0;
               par_bad_d = 1'b0;
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d       = '0;
               sr_d[idx_q] = rx_s;
               if (idx_q == LAST_BIT) begin
                  state_d = PAR_EN ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               par_bad_d = rx_s != ((^sr_q) ^ PAR_ODD_BIT);
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Leave at mid-stop-bit so a start edge immediately after the stop bit is caught.
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (!rx_s) begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end else if (PAR_EN && par_bad_q) begin
                  perr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  valid_d  = 1'b1;
                  packet_d = sr_q;
                  state_d  = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if ((ferr_d || perr_d) && (errcnt_q != 8'hFF)) begin
         errcnt_d = errcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sr_q      <= '0;
         par_bad_q <= 1'b0;
         valid_q   <= 1'b0;
         packet_q  <= '0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         errcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sr_q      <= sr_d;
         par_bad_q <= par_bad_d;
         valid_q   <= valid_d;
         packet_q  <= packet_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         errcnt_q  <= errcnt_d;
      end
   end

   assign io_data_valid   = valid_q;
   assign io_data_packet  = packet_q;
   assign io_frame_error  = ferr_q;
   assign io_parity_error = perr_q;
   assign io_error_count  = errcnt_q;
   assign io_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: frame-level event model with directed and random frames.
module tb_uart_rx_param;

   localparam int unsigned FREQ = 50_000_000;
   localparam int unsigned BAUD = 6_250_000;
   localparam int CPB  = FREQ / BAUD;
   localparam int DB   = 8;
   localparam int SS   = 2;
   localparam int PODD = 0;
   localparam int TOL  = 2;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         io_rx = 1'b1;
   logic         io_data_valid;
   logic [DB-1:0] io_data_packet;
   logic         io_frame_error;
   logic         io_parity_error;
   logic [7:0]   io_error_count;
   logic         io_busy;

   uart_rx_param #(
      .FREQUENCY_IN_HZ(FREQ),
      .BAUD           (BAUD),
      .DATA_BITS      (DB),
      .SYNC_STAGES    (SS),
      .PARITY_ODD     (PODD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .io_rx          (io_rx),
      .io_data_valid  (io_data_valid),
      .io_data_packet (io_data_packet),
      .io_frame_error (io_frame_error),
      .io_parity_error(io_parity_error),
      .io_error_count (io_error_count),
      .io_busy        (io_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // kind: 0 = good frame, 1 = framing error, 2 = parity error
   typedef struct {
      int         kind;
      logic [7:0] data;
      int         due;
   } ev_t;
   ev_t q[$];
   logic [7:0] m_pkt = '0;
   int         m_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_window(input string name, input int act, input int exp);
      checks++;
      if (act < exp - TOL || act > exp + TOL) begin
         failures++;
         $display("FAIL %s actual_cycle=%0d expected_cycle=%0d+-%0d", name, act, exp, TOL);
      end
   endtask

   // Compare process: pulses are matched in order against the expected event queue.
   initial forever begin
      int npulse;
      int kind;
      ev_t e;
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
         m_pkt = '0;
         m_cnt = 0;
         check("rst_valid",  int'(io_data_valid), 0);
         check("rst_ferr",   int'(io_frame_error), 0);
         check("rst_perr",   int'(io_parity_error), 0);
         check("rst_packet", int'(io_data_packet), 0);
         check("rst_count",  int'(io_error_count), 0);
         check("rst_busy",   int'(io_busy), 0);
      end else begin
         npulse = int'(io_data_valid) + int'(io_frame_error) + int'(io_parity_error);
         if (npulse > 1) begin
            check("pulse_exclusive", npulse, 1);
         end else if (npulse == 1) begin
            kind = io_data_valid ? 0 : (io_frame_error ? 1 : 2);
            if (q.size() == 0) begin
               check("unexpected_pulse_kind", kind, -1);
            end else begin
               e = q.pop_front();
               check("event_kind", kind, e.kind);
               check_window("event_latency", cyc, e.due);
               if (e.kind == 0) m_pkt = e.data;
               else if (m_cnt < 255) m_cnt++;
            end
         end else if (q.size() > 0 && cyc > q[0].due + TOL) begin
            check("missing_event_at_cycle", cyc, q[0].due);
            void'(q.pop_front());
         end
         check("packet", int'(io_data_packet), int'(m_pkt));
         check("error_count", int'(io_error_count), m_cnt);
      end
   end

   task automatic idle_bits(input int n);
      repeat (n * CPB) @(negedge clk);
   endtask

   // Drive one frame; abort_bit >= 0 fires a reset pulse in the middle of that data bit.
   task automatic send(input logic [7:0] d, input logic stop_v, input logic flip,
                       input int stop_hold, input int abort_bit);
      int  c;
      ev_t e;
      @(negedge clk);
      c = cyc;
      io_rx = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < DB; i++) begin
         @(negedge clk);
         io_rx = d[i];
         if (i == abort_bit) begin
            repeat (CPB / 2) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            io_rx = 1'b1;
            return;
         end
         if (i == 4) check("busy_mid_frame", int'(io_busy), 1);
         repeat (CPB - 1) @(negedge clk);
      end
      if (PB != 0) begin
         @(negedge clk);
         io_rx = (^d) ^ (PODD != 0) ^ flip;
         repeat (CPB - 1) @(negedge clk);
      end
      e.kind = (stop_v == 1'b0) ? 1 : ((PB != 0 && flip) ? 2 : 0);
      e.data = d;
      e.due  = c + SS + 1 + CPB / 2 + (DB + PB + 1) * CPB;
      q.push_back(e);
      @(negedge clk);
      io_rx = stop_v;
      repeat (CPB * stop_hold - 1) @(negedge clk);
      @(negedge clk);
      io_rx = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int r;
      logic bad_stop;
      logic flip;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle_bits(1);

      send(8'h93, 1'b1, 1'b0, 1, -1);
      idle_bits(2);
      check("t1_packet_93", int'(io_data_packet), 8'h93);
      check("t1_busy_idle", int'(io_busy), 0);

      send(8'h93, 1'b1, 1'b0, 1, -1);
      send(8'h00, 1'b1, 1'b0, 1, -1);
      send(8'h40, 1'b1, 1'b0, 1, -1);
      send(8'h00, 1'b1, 1'b0, 1, -1);
      idle_bits(2);
      check("t2_packet_00", int'(io_data_packet), 8'h00);

      @(negedge clk);
      io_rx = 1'b0;
      repeat (CPB / 2 - 2) @(negedge clk);
      io_rx = 1'b1;
      idle_bits(2);
      check("t3_glitch_busy", int'(io_busy), 0);

      send(8'h55, 1'b0, 1'b0, 4, -1);
      idle_bits(1);
      check("t4_err_count_1", int'(io_error_count), 1);
      check("t4_packet_kept", int'(io_data_packet), 8'h00);
      send(8'hA5, 1'b1, 1'b0, 1, -1);
      idle_bits(2);
      check("t4_packet_a5", int'(io_data_packet), 8'hA5);

      send(8'h3C, 1'b1, 1'b0, 1, 3);
      idle_bits(2);
      check("t5_after_reset_pkt", int'(io_data_packet), 0);
      send(8'hA5, 1'b1, 1'b0, 1, -1);
      idle_bits(2);
      check("t5_packet_a5", int'(io_data_packet), 8'hA5);
      check("t5_count_cleared", int'(io_error_count), 0);

      if (PB != 0) begin
         send(8'h93, 1'b1, 1'b0, 1, -1);
         idle_bits(2);
         check("t6_parity_ok_pkt", int'(io_data_packet), 8'h93);
         send(8'h93, 1'b1, 1'b1, 1, -1);
         idle_bits(2);
         check("t6_parity_bad_pkt", int'(io_data_packet), 8'h93);
         check("t6_parity_count", int'(io_error_count), 1);
      end

      for (int n = 0; n < 40; n++) begin
         d        = 8'($urandom);
         r        = int'($urandom_range(0, 9));
         bad_stop = (r == 0);
         flip     = (r == 1);
         send(d, !bad_stop, flip, bad_stop ? int'($urandom_range(1, 3)) : 1, -1);
         idle_bits(bad_stop ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2)));
      end
      idle_bits(2);

      for (int n = 0; n < 260; n++) begin
         send(8'($urandom), 1'b0, 1'b0, 1, -1);
         idle_bits(1);
      end
      idle_bits(2);
      check("sat_count_255", int'(io_error_count), 255);
      check("final_busy", int'(io_busy), 0);
      check("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
